// File: rtl/reaction_game_controller.sv
// reaction_game_controller: round sequencer for the LED-matching reaction game
module reaction_game_controller #(
   parameter int          CLKS_PER_SEC  = 50_000_000,
   parameter int          START_SECONDS = 10,
   parameter logic [17:0] LFSR_SEED     = 18'h00001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [17:0] switches,
   output logic [17:0] target,
   output logic [10:0] time_left,
   output logic [10:0] score,
   output logic        playing,
   output logic        game_over
);
   localparam int CW = CLKS_PER_SEC > 1 ? $clog2(CLKS_PER_SEC) : 1;
   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
   state_t        state;
   logic [CW-1:0] sec_cnt;
   logic [17:0]   lfsr;
   logic [17:0]   lfsr_next;
   logic          tick;
   logic          match;
   always_comb begin
      lfsr_next = {lfsr[16:0], lfsr[17] ^ lfsr[10]};
      tick      = sec_cnt == CW'(CLKS_PER_SEC - 1);
      match     = switches == target;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lfsr      <= LFSR_SEED;
         sec_cnt   <= '0;
         target    <= '0;
         time_left <= '0;
         score     <= '0;
         playing   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         lfsr <= lfsr_next;
         case (state)
            PLAY: begin
               sec_cnt <= tick ? '0 : sec_cnt + CW'(1);
               if (match) begin
                  score  <= score == 11'h7FF ? score : score + 11'd1;
                  target <= lfsr != target ? lfsr : lfsr_next;
               end
               if (tick)
                  time_left <= time_left - 11'd1;
               // Final tick wins over a same-cycle match for the target; score still counts.
               if (tick && time_left == 11'd1) begin
                  state     <= OVER;
                  target    <= '0;
                  playing   <= 1'b0;
                  game_over <= 1'b1;
               end
            end
            default: if (start) begin
               state     <= PLAY;
               time_left <= 11'(START_SECONDS);
               score     <= '0;
               sec_cnt   <= '0;
               target    <= lfsr;
               playing   <= 1'b1;
               game_over <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_reaction_game_controller.sv
// tb_reaction_game_controller: scoreboard bench against a cycle model of the game
module tb_reaction_game_controller;
   localparam int CPS = 4;
   localparam int SECS = 10;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [17:0] switches = '0;
   logic [17:0] target;
   logic [10:0] time_left;
   logic [10:0] score;
   logic        playing;
   logic        game_over;
   int          total = 0;
   int          bad = 0;
   int          m_st = 0;
   int          m_sec = 0;
   int          m_time = 0;
   int          m_score = 0;
   logic [17:0] m_tgt = '0;
   logic [17:0] m_lfsr = 18'h00001;
   logic [41:0] sb[$];
   reaction_game_controller #(.CLKS_PER_SEC(CPS), .START_SECONDS(SECS), .LFSR_SEED(18'h00001)) dut (
      .clk(clk), .reset(reset), .start(start), .switches(switches), .target(target),
      .time_left(time_left), .score(score), .playing(playing), .game_over(game_over)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step(input logic r, input logic s, input logic [17:0] w);
      logic [17:0] nl;
      logic [41:0] e;
      bit          tk;
      reset = r;
      start = s;
      switches = w;
      nl = {m_lfsr[16:0], m_lfsr[17] ^ m_lfsr[10]};
      if (r) begin
         m_st = 0; m_lfsr = 18'h00001; m_sec = 0; m_time = 0; m_score = 0; m_tgt = '0;
      end else begin
         if (m_st == 1) begin
            tk = m_sec == CPS - 1;
            if (w == m_tgt) begin
               m_score = m_score == 2047 ? 2047 : m_score + 1;
               m_tgt = m_lfsr != m_tgt ? m_lfsr : nl;
            end
            m_sec = tk ? 0 : m_sec + 1;
            if (tk) begin
               m_time--;
               if (m_time == 0) begin m_st = 2; m_tgt = '0; end
            end
         end else if (s) begin
            m_st = 1; m_time = SECS; m_score = 0; m_sec = 0; m_tgt = m_lfsr;
         end
         m_lfsr = nl;
      end
      sb.push_back({m_tgt, 11'(m_time), 11'(m_score), m_st == 1, m_st == 2});
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("sb_empty", 0, 1);
      else begin
         e = sb.pop_front();
         chk("target", 32'(target), 32'(e[41:24]));
         chk("time_left", 32'(time_left), 32'(e[23:13]));
         chk("score", 32'(score), 32'(e[12:2]));
         chk("playing", 32'(playing), 32'(e[1]));
         chk("game_over", 32'(game_over), 32'(e[0]));
      end
   endtask
   initial begin
      logic [17:0] prev;
      int          sc;
      int          n;
      repeat (3) step(1, 0, '0);
      chk("rst_target", 32'(target), 0);
      chk("rst_playing", 32'(playing), 0);
      repeat (20) step(0, 0, '0);
      chk("idle_over", 32'(game_over), 0);
      chk("idle_time", 32'(time_left), 0);
      step(0, 1, '0);
      chk("start_time", 32'(time_left), SECS);
      chk("start_tgt_nz", 32'(target != 0), 1);
      for (int i = 1; i <= SECS * CPS; i++) begin
         step(0, 0, '0);
         if (i == CPS) chk("first_dec", 32'(time_left), SECS - 1);
         if (i == SECS * CPS - 1) chk("pre_over", 32'(game_over), 0);
      end
      chk("over_flag", 32'(game_over), 1);
      chk("over_time", 32'(time_left), 0);
      chk("over_score", 32'(score), 0);
      chk("over_target", 32'(target), 0);
      step(0, 1, '0);
      chk("restart_score", 32'(score), 0);
      chk("restart_time", 32'(time_left), SECS);
      chk("restart_play", 32'(playing), 1);
      for (int i = 1; i <= 5; i++) begin
         prev = target;
         step(0, 0, m_tgt);
         chk("score_inc", 32'(score), 32'(i));
         chk("tgt_changed", 32'(target != prev), 1);
         chk("tgt_nonzero", 32'(target != 0), 1);
      end
      sc = score;
      step(0, 1, '0);
      chk("midplay_start_score", 32'(score), 32'(sc));
      chk("midplay_start_play", 32'(playing), 1);
      n = 0;
      while (!(m_time == 1 && m_sec == CPS - 1) && n < 200) begin step(0, 0, '0); n++; end
      chk("wait_final_tick", 32'(n < 200), 1);
      sc = score;
      step(0, 0, m_tgt);
      chk("final_match_score", 32'(score), 32'(sc + 1));
      chk("final_match_over", 32'(game_over), 1);
      chk("final_match_tgt", 32'(target), 0);
      step(0, 1, '0);
      repeat (3) step(0, 0, m_tgt);
      chk("mid_score3", 32'(score), 3);
      n = 0;
      while (m_time != 6 && n < 200) begin step(0, 0, '0); n++; end
      chk("wait_six", 32'(n < 200), 1);
      step(1, 1, m_tgt);
      chk("midrst_target", 32'(target), 0);
      chk("midrst_time", 32'(time_left), 0);
      chk("midrst_score", 32'(score), 0);
      chk("midrst_playing", 32'(playing), 0);
      step(0, 0, '0);
      step(0, 1, '0);
      chk("fresh_time", 32'(time_left), SECS);
      chk("fresh_score", 32'(score), 0);
      chk("fresh_play", 32'(playing), 1);
      repeat (6) step(0, 0, '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reaction_game_controller.md
# reaction_game_controller

Round sequencer for the LED-matching reaction game on the DE2 board. It sits between the debounced KEY/SW inputs and the LEDR/seven-segment drivers. On a start pulse it runs a countdown of START_SECONDS seconds and presents a pseudo-random target pattern on the LEDs. Each time the switches equal the target, it adds one to the score and presents a new target. It holds the final score once time expires.

## Interface
- CLKS_PER_SEC, default 50_000_000: clock cycles per game second. The top level divides this by SCALE_FACTOR for simulation.
- START_SECONDS, default 10: countdown load value. Range 1..2047.
- LFSR_SEED, default 18'h00001: reset value of the target generator. Must be nonzero.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse from debounced KEY[0].
- switches  in  18  SW[17:0].
- target  out  18  pattern driven to LEDR.
- time_left  out  11  remaining seconds, for BCD/HEX display.
- score  out  11  matches this game, for BCD/HEX display.
- playing  out  1  high in PLAY.
- game_over  out  1  high in OVER.

## Operation
- **States:** IDLE, PLAY, OVER, encoded in 2 bits. Reset leads to IDLE.
- **Reset values (all outputs registered):**
  - target = 0, time_left = 0, score = 0, playing = 0, game_over = 0.
  - Internal: sec_cnt = 0, lfsr = LFSR_SEED.
- **LFSR:** 18-bit Fibonacci, polynomial x^18+x^11+1, maximal length. It shifts every cycle in every state, including during reset deassertion. It never reaches 0.
- **IDLE or OVER, with start = 1:**
  - Go to PLAY.
  - time_left <= START_SECONDS, score <= 0, sec_cnt <= 0, target <= lfsr.
- **IDLE:** target = 0.
- **OVER:** target = 0; time_left and score hold.
- **PLAY, start = 1:** ignored. No restart mid-game.
- **PLAY, second counter:**
  - sec_cnt counts 0..CLKS_PER_SEC-1 and wraps.
  - tick = (sec_cnt == CLKS_PER_SEC-1).
  - On tick, time_left decrements.
  - If tick and time_left == 1: time_left <= 0 and go to OVER.
- **PLAY, match** (match = switches == target, combinational compare, registered effects):
  - score <= score + 1, saturating at 2047.
  - target <= lfsr if lfsr != target; otherwise target <= next LFSR state. Consecutive LFSR states always differ, so a new target never equals the old one.
- **Match and final tick in the same cycle:** the score increments first, then OVER is entered. The new target is discarded because target is 0 in OVER.
- **Switches held equal across a target change:** no double count, because the new target differs from the held switches.
- **reset = 1 in any state:** forces reset values on the next edge. It overrides start and match.

## Timing
- start sampled at edge N: playing = 1, time_left = START_SECONDS, and a nonzero target are visible after edge N.
- First decrement: edge N + CLKS_PER_SEC. Subsequent decrements every CLKS_PER_SEC cycles.
- OVER entry: edge N + START_SECONDS × CLKS_PER_SEC. game_over rises and playing falls on the same edge.
- Match sampled at edge M: score and target update on edge M. A one-cycle-late switch change is counted only against the new target.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use CLKS_PER_SEC = 4, START_SECONDS = 10.

- **Reset:** reset high for 3 cycles, then low -> all outputs 0, state IDLE. No change for 20 idle cycles with start = 0.
- **Start and countdown:** start pulse, switches = 0 -> time_left = 10 next cycle, then 9 after 4 more cycles. game_over = 1 and time_left = 0 exactly 40 cycles after start. score = 0, target = 0 in OVER.
- **Scoring:** in PLAY, set switches = target each cycle for 5 cycles -> score goes 1..5. Each new target differs from the previous one, and none is 0.
- **Simultaneous match and final tick:** match applied on the cycle time_left goes 1 -> 0 -> score increments by 1 and game_over = 1.
- **Restart from OVER and ignored start:**
  - start in OVER -> score = 0, time_left = 10, playing = 1.
  - start pulse mid-PLAY -> time_left and score unaffected.
- **Reset mid-game:** reset asserted at time_left = 6, score = 3 -> next cycle all outputs 0, state IDLE. A subsequent start behaves as a fresh game.
